// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: single-outstanding sequential fetch into a PC-tagged prefetch FIFO.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RedirectE,
  input  logic [31:0] PCTargetE,
  input  logic        InstrReadyD,
  output logic        InstrValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP_REQ, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] issue_pc_q, issue_pc_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];

  logic [31:0] target;
  logic        empty, full, rsp_ok, bypass, push, pop;

  assign target = PCTargetE & ~32'h0000_0003;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rsp_ok = (state_q == WAIT) && IMemRValid && !RedirectE;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = empty && rsp_ok;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes this cycle never occupies a queue slot.
  assign push        = rsp_ok && !(bypass && InstrReadyD);
  assign pop         = !empty && InstrReadyD && !RedirectE;
  assign InstrValidF = !empty || bypass;
  assign IMemReq     = (state_q == REQ) || (state_q == DROP_REQ);
  assign IMemAddr    = issue_pc_q;
  assign PCPlus4F    = PCF + 32'd4;

  always_comb begin
    InstrF = NOP;
    PCF    = 32'h0000_0000;
    if (bypass) begin
      InstrF = IMemRData;
      PCF    = issue_pc_q;
    end else if (!empty) begin
      InstrF = instr_mem_q[rd_ptr_q[AW-1:0]];
      PCF    = pc_mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Fetch FSM: only IDLE issues, so an empty IDLE slot check reserves room for the response.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    unique case (state_q)
      IDLE: begin
        if (RedirectE) begin
          state_d    = REQ;
          issue_pc_d = target;
        end else if (!full) begin
          state_d    = REQ;
          issue_pc_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (RedirectE) begin
          state_d = IMemGnt ? DROP : DROP_REQ;
        end else if (IMemGnt) begin
          state_d    = WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (RedirectE) state_d = IMemRValid ? IDLE : DROP;
        else if (IMemRValid) state_d = IDLE;
      end
      DROP_REQ: if (IMemGnt) state_d = DROP;
      DROP:     if (IMemRValid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (RedirectE) fetch_pc_d = target;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (RedirectE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem_q[wr_ptr_q[AW-1:0]] <= IMemRData;
      pc_mem_q[wr_ptr_q[AW-1:0]]    <= issue_pc_q;
    end
  end

endmodule
